mem_io_responder: RTL and testbench

Memory-side responder for the SLC-3 datapath's MAR/MDR memory interface. It accepts read/write requests addressed by MAR with write data from MDR, services them from an on-chip word array or from the memory-mapped I/O location, and returns read data on MDR_In. It asserts a one-cycle ready pulse, R, that the control unit waits on in its memory states. It sits between the datapath and the board (switches in, hex display register out).

---
 rtl/mem_io_responder_pkg.sv | 24 ++
 rtl/mem_io_responder_if.sv | 31 +++
 rtl/mem_io_responder_sram_sp.sv | 26 ++
 rtl/mem_io_responder.sv | 142 ++++++++++++++
 tb/tb_mem_io_responder.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared SLC-3 package: the responder FSM state type, the word type and the
// default I/O address decoded by the memory responder.
package slc3_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } memio_state_t;

    localparam word_t IO_ADDR_DEFAULT = 16'hFFFF;

    // Width of the wait-state counter; WAIT_STATES is limited to 0..15.
    localparam int COUNT_W = 4;

    // The I/O location is a full 16-bit match, so it is decoded before any
    // array aliasing is applied.
    function automatic logic is_io_addr(input word_t addr, input word_t io_addr);
        return (addr == io_addr);
    endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// MAR/MDR memory bus between the SLC-3 datapath (master) and the memory
// responder (slave).
interface mem_io_responder_if;
    import slc3_pkg::*;

    logic  MEM_EN;
    logic  WE;
    word_t MAR;
    word_t MDR;
    word_t MDR_In;
    logic  R;

    modport master (
        output MEM_EN,
        output WE,
        output MAR,
        output MDR,
        input  MDR_In,
        input  R
    );

    modport slave (
        input  MEM_EN,
        input  WE,
        input  MAR,
        input  MDR,
        output MDR_In,
        output R
    );

endinterface

// File: rtl/mem_io_responder_sram_sp.sv
// Single-port synchronous RAM holding the on-chip word array. Reads are
// registered; a write and a read on the same edge return the old contents.
// Contents are not initialised and are not touched by reset.
module sram_sp
    import slc3_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  word_t             din,
    output word_t             dout
);

    word_t mem [2**ADDR_W];

    // Write when enabled and always register the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder for the SLC-3 MAR/MDR interface. A request is latched
// in IDLE, waits WAIT_STATES cycles in BUSY, commits on the edge leaving BUSY
// and signals completion with a one-cycle R pulse in DONE. Address IO_ADDR
// maps to the switches (read) and the hex display register (write); every
// other address aliases into the on-chip array modulo its depth.
module mem_io_responder
    import slc3_pkg::*;
#(
    parameter int    ADDR_W      = 10,
    parameter int    WAIT_STATES = 2,
    parameter word_t IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    mem_io_responder_if.slave   bus,
    input  word_t               SW,
    output word_t               HEX_OUT
);

    localparam logic [COUNT_W-1:0] WS_LOAD = COUNT_W'(WAIT_STATES);

    memio_state_t       state;
    memio_state_t       state_next;
    logic [COUNT_W-1:0] count;

    word_t addr_q;
    word_t wdata_q;
    logic  we_q;

    word_t sw_meta;
    word_t sw_sync;

    word_t mdr_in_q;
    word_t hex_q;

    logic              commit;
    logic              is_io;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    word_t             ram_dout;

    // The access completes on the edge that leaves BUSY with the counter at 0.
    assign commit = (state == BUSY) && (count == '0);
    assign is_io  = is_io_addr(addr_q, IO_ADDR);

    // The RAM read must be issued one cycle before commit. With wait states
    // that cycle is a BUSY cycle using the latched address; with zero wait
    // states it is the IDLE request cycle, so the incoming MAR is used there.
    assign ram_addr = (state == IDLE) ? bus.MAR[ADDR_W-1:0] : addr_q[ADDR_W-1:0];

    // Reset on the commit edge cancels the array write.
    assign ram_we = commit && we_q && !is_io && !reset;

    sram_sp #(
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk  (clk),
        .addr (ram_addr),
        .we   (ram_we),
        .din  (wdata_q),
        .dout (ram_dout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: MEM_EN only matters in IDLE; DONE always returns.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.MEM_EN) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (count == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the request and run the wait-state counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if ((state == IDLE) && bus.MEM_EN) begin
            count   <= WS_LOAD;
            addr_q  <= bus.MAR;
            wdata_q <= bus.MDR;
            we_q    <= bus.WE;
        end else if ((state == BUSY) && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Two-flop synchronizer for the asynchronous board switches.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
        end
    end

    // Commit: reads load MDR_In, I/O writes load the hex display register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mdr_in_q <= '0;
            hex_q    <= '0;
        end else if (commit) begin
            if (!we_q) begin
                mdr_in_q <= is_io ? sw_sync : ram_dout;
            end else if (is_io) begin
                hex_q <= wdata_q;
            end
        end
    end

    assign bus.MDR_In = mdr_in_q;
    assign bus.R      = (state == DONE);
    assign HEX_OUT    = hex_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder with WAIT_STATES=2, ADDR_W=10.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_mem_io_responder;
    import slc3_pkg::*;

    localparam int    ADDR_W = 10;
    localparam int    WS     = 2;
    localparam int    R_LAT  = WS + 2;
    localparam int    DEPTH  = 1 << ADDR_W;
    localparam word_t IO_A   = 16'hFFFF;

    logic  clk = 1'b0;
    logic  reset;
    word_t SW;
    word_t HEX_OUT;

    mem_io_responder_if bus();

    mem_io_responder #(
        .ADDR_W      (ADDR_W),
        .WAIT_STATES (WS),
        .IO_ADDR     (IO_A)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .SW      (SW),
        .HEX_OUT (HEX_OUT)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: word array with known flags, display register, last read.
    word_t mem_model [DEPTH];
    bit    known     [DEPTH];
    word_t hex_model;
    word_t mdr_model;
    int    known_idx [$];

    function automatic int idx_of(input word_t a);
        return int'(a) % DEPTH;
    endfunction

    // Apply one completed access to the model and return the MDR_In expected after it.
    function automatic word_t model_commit(input logic we, input word_t a, input word_t d, input word_t sw);
        if (we) begin
            if (a == IO_A) hex_model = d;
            else begin
                mem_model[idx_of(a)] = d;
                if (!known[idx_of(a)]) known_idx.push_back(idx_of(a));
                known[idx_of(a)] = 1'b1;
            end
        end else begin
            mdr_model = (a == IO_A) ? sw : mem_model[idx_of(a)];
        end
        return mdr_model;
    endfunction

    // Issue one request, scramble the bus after the request cycle, and report
    // the cycle R was first seen (-1 if never within 8 cycles) and MDR_In then.
    task automatic do_access(input logic we, input word_t a, input word_t d,
                             input word_t sw_early, input word_t sw_late,
                             output int r_cycle, output word_t rdata);
        @(negedge clk);
        SW         = sw_early;
        bus.MEM_EN = 1'b1;
        bus.WE     = we;
        bus.MAR    = a;
        bus.MDR    = d;
        r_cycle    = -1;
        rdata      = 'x;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.R === 1'b1) begin
                r_cycle = k;
                rdata   = bus.MDR_In;
            end
            if (k == 1) begin
                bus.MEM_EN = 1'b0;
                bus.WE     = 1'($urandom);
                bus.MAR    = 16'($urandom);
                bus.MDR    = 16'($urandom);
            end
            if (k == 2) SW = sw_late;
            if (r_cycle > 0) break;
        end
    endtask

    task automatic test_reset();
        int pulses;
        reset      = 1'b1;
        bus.MEM_EN = 1'b1;
        bus.WE     = 1'b1;
        bus.MAR    = IO_A;
        bus.MDR    = 16'h1111;
        SW         = 16'h0000;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        hex_model = 16'h0000;
        mdr_model = 16'h0000;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (bus.R !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_r cycle %0d: got %b want 0", k, bus.R);
            end
        end
        total++;
        if (bus.MDR_In !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL reset_mdr_in: got %h want 0000", bus.MDR_In);
        end
        total++;
        if (HEX_OUT !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL reset_hex_out: got %h want 0000", HEX_OUT);
        end
        reset      = 1'b0;
        bus.MEM_EN = 1'b0;
        pulses     = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.R === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0 || HEX_OUT !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL reset_no_latch: pulses %0d hex %h want 0 pulses hex 0000", pulses, HEX_OUT);
        end
    endtask

    task automatic test_write_read();
        int    rc;
        word_t rd;
        word_t exp;
        exp = model_commit(1'b1, 16'h0010, 16'h1234, 16'h0000);
        do_access(1'b1, 16'h0010, 16'h1234, 16'h0000, 16'h0000, rc, rd);
        total++;
        if (rc != R_LAT) begin
            bad++;
            $display("[TB] FAIL wr_r_cycle: got %0d want %0d", rc, R_LAT);
        end
        total++;
        if (rd !== exp) begin
            bad++;
            $display("[TB] FAIL wr_mdr_hold: got %h want %h", rd, exp);
        end
        exp = model_commit(1'b0, 16'h0010, 16'h0000, 16'h0000);
        do_access(1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h0000, rc, rd);
        total++;
        if (rc != R_LAT) begin
            bad++;
            $display("[TB] FAIL rd_r_cycle: got %0d want %0d", rc, R_LAT);
        end
        total++;
        if (rd !== 16'h1234) begin
            bad++;
            $display("[TB] FAIL rd_data: got %h want 1234", rd);
        end
        repeat (2) @(negedge clk);
        total++;
        if (bus.MDR_In !== exp) begin
            bad++;
            $display("[TB] FAIL rd_data_stays: got %h want %h", bus.MDR_In, exp);
        end
    endtask

    task automatic test_io_write_alias();
        int    rc;
        word_t rd;
        word_t exp;
        exp = model_commit(1'b1, 16'h03FF, 16'hBEEF, 16'h0000);
        do_access(1'b1, 16'h03FF, 16'hBEEF, 16'h0000, 16'h0000, rc, rd);
        exp = model_commit(1'b1, IO_A, 16'h0F0F, 16'h0000);
        do_access(1'b1, IO_A, 16'h0F0F, 16'h0000, 16'h0000, rc, rd);
        total++;
        if (rc != R_LAT) begin
            bad++;
            $display("[TB] FAIL io_wr_r_cycle: got %0d want %0d", rc, R_LAT);
        end
        total++;
        if (HEX_OUT !== 16'h0F0F) begin
            bad++;
            $display("[TB] FAIL io_wr_hex: got %h want 0F0F", HEX_OUT);
        end
        exp = model_commit(1'b0, 16'h03FF, 16'h0000, 16'h0000);
        do_access(1'b0, 16'h03FF, 16'h0000, 16'h0000, 16'h0000, rc, rd);
        total++;
        if (rd !== 16'hBEEF || rd !== exp) begin
            bad++;
            $display("[TB] FAIL io_no_alias: got %h want BEEF", rd);
        end
    endtask

    task automatic test_io_read();
        int    rc;
        word_t rd;
        word_t exp;
        SW = 16'h00A5;
        repeat (4) @(negedge clk);
        exp = model_commit(1'b0, IO_A, 16'h0000, 16'h00A5);
        do_access(1'b0, IO_A, 16'h0000, 16'h00A5, 16'h00A5, rc, rd);
        total++;
        if (rc != R_LAT || rd !== 16'h00A5) begin
            bad++;
            $display("[TB] FAIL io_rd: got cycle %0d data %h want cycle %0d data 00A5", rc, rd, R_LAT);
        end
        // A switch change in the cycle just before commit is still in the synchronizer.
        exp = model_commit(1'b0, IO_A, 16'h0000, 16'h5A3C);
        do_access(1'b0, IO_A, 16'h0000, 16'h5A3C, 16'hC3C3, rc, rd);
        total++;
        if (rd !== exp) begin
            bad++;
            $display("[TB] FAIL io_rd_sync_depth: got %h want %h", rd, exp);
        end
    endtask

    task automatic test_alias();
        int    rc;
        word_t rd;
        word_t exp;
        exp = model_commit(1'b1, 16'h0400, 16'h5555, 16'h0000);
        do_access(1'b1, 16'h0400, 16'h5555, 16'h0000, 16'h0000, rc, rd);
        exp = model_commit(1'b0, 16'h0000, 16'h0000, 16'h0000);
        do_access(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, rc, rd);
        total++;
        if (rd !== 16'h5555 || rd !== exp) begin
            bad++;
            $display("[TB] FAIL alias_rd: got %h want 5555", rd);
        end
    endtask

    task automatic test_back_to_back();
        int    rc;
        word_t rd;
        word_t exp;
        logic  want_r;
        exp = model_commit(1'b1, 16'h0020, 16'h1357, 16'h0000);
        do_access(1'b1, 16'h0020, 16'h1357, 16'h0000, 16'h0000, rc, rd);
        exp = model_commit(1'b0, 16'h0010, 16'h0000, 16'h0000);
        @(negedge clk);
        bus.MEM_EN = 1'b1;
        bus.WE     = 1'b0;
        bus.MAR    = 16'h0010;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            want_r = (k % (WS + 3)) == R_LAT;
            total++;
            if (bus.R !== want_r) begin
                bad++;
                $display("[TB] FAIL b2b_r cycle %0d: got %b want %b", k, bus.R, want_r);
            end
            if (want_r) begin
                total++;
                if (bus.MDR_In !== exp) begin
                    bad++;
                    $display("[TB] FAIL b2b_data cycle %0d: got %h want %h", k, bus.MDR_In, exp);
                end
            end
            if (k == 14) bus.MEM_EN = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset(input word_t a, input word_t d, input int reset_at);
        int    pulses;
        int    rc;
        word_t rd;
        word_t exp;
        @(negedge clk);
        bus.MEM_EN = 1'b1;
        bus.WE     = 1'b1;
        bus.MAR    = a;
        bus.MDR    = d;
        pulses     = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.R === 1'b1) pulses++;
            if (k == 1) bus.MEM_EN = 1'b0;
            if (k == reset_at) reset = 1'b1;
            if (k == reset_at + 1) reset = 1'b0;
        end
        hex_model = 16'h0000;
        mdr_model = 16'h0000;
        total++;
        if (pulses != 0) begin
            bad++;
            $display("[TB] FAIL mid_reset_r at %0d: got %0d pulses want 0", reset_at, pulses);
        end
        total++;
        if (bus.MDR_In !== 16'h0000 || HEX_OUT !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL mid_reset_regs at %0d: got mdr %h hex %h want 0000 0000", reset_at, bus.MDR_In, HEX_OUT);
        end
        exp = model_commit(1'b0, a, 16'h0000, 16'h0000);
        do_access(1'b0, a, 16'h0000, 16'h0000, 16'h0000, rc, rd);
        total++;
        if (rc != R_LAT || rd !== exp) begin
            bad++;
            $display("[TB] FAIL mid_reset_prior at %0d: got cycle %0d data %h want cycle %0d data %h", reset_at, rc, rd, R_LAT, exp);
        end
    endtask

    task automatic test_random();
        int    rc;
        word_t rd;
        word_t exp;
        word_t a;
        word_t d;
        word_t sw_e;
        word_t sw_l;
        logic  we;
        for (int n = 0; n < 30; n++) begin
            we   = (known_idx.size() == 0) ? 1'b1 : 1'($urandom);
            d    = 16'($urandom);
            sw_e = 16'($urandom);
            sw_l = 16'($urandom);
            if ($urandom_range(0, 4) == 0) a = IO_A;
            else if (we) a = 16'($urandom);
            else a = {6'($urandom), 10'(known_idx[$urandom_range(0, known_idx.size() - 1)])};
            exp = model_commit(we, a, d, sw_e);
            do_access(we, a, d, sw_e, sw_l, rc, rd);
            total++;
            if (rc != R_LAT || rd !== exp) begin
                bad++;
                $display("[TB] FAIL rand_%0d we=%b addr=%h: got cycle %0d data %h want cycle %0d data %h", n, we, a, rc, rd, R_LAT, exp);
            end
            total++;
            if (HEX_OUT !== hex_model) begin
                bad++;
                $display("[TB] FAIL rand_hex_%0d: got %h want %h", n, HEX_OUT, hex_model);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_io_write_alias();
        test_io_read();
        test_alias();
        test_back_to_back();
        test_mid_reset(16'h0020, 16'hAAAA, 2);
        test_mid_reset(16'h0020, 16'h7777, 3);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
